// File: rtl/prach_pkg.sv
// Shared PRACH definitions: triple phase encoding and the cos(pi/6) coefficient.
package prach_pkg;

  typedef enum logic [1:0] {
    PH_X0 = 2'd0,
    PH_X1 = 2'd1,
    PH_X2 = 2'd2
  } phase_e;

  // round(cos(pi/6) * 2^(cw-2)) = round(sqrt(3 * 4^(cw-3))), by integer square root
  function automatic int cos_pi6(input int cw);
    longint n, r, t;
    n = longint'(3) << (2 * (cw - 3));
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= n) r = t;
    end
    if (n > r * r + r) r = r + 1;
    return int'(r);
  endfunction

endpackage

// File: rtl/delay.sv
// Fixed-depth register delay line, cleared by reset.
module delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/prach_ditfft3_bf2_p.sv
// Radix-3 DIT butterfly (partial): streams y0, y1 and the j*c*x2 term, 5-cycle latency.
// Define PRACH_BF3_ROUND_EN for round-half-up; otherwise results are truncated.
module prach_ditfft3_bf2_p
  import prach_pkg::*;
#(
  parameter int DW = 18,
  parameter int CW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_dr,
  input  logic [DW-1:0] din_di,
  input  logic          din_dv,
  input  logic          sync_in,
  input  logic          inv,
  output logic [DW-1:0] dout_dr,
  output logic [DW-1:0] dout_di,
  output logic          dout_dv,
  output logic          sync_out,
  output logic          ovf,
  output logic          sync_err
);

  localparam int C  = cos_pi6(CW);
  localparam int PW = DW + CW;
  localparam int EW = DW + 2;
  localparam int LW = 2 * DW + 4;

  localparam logic signed [CW-1:0] CP   = CW'(C);
  localparam logic signed [CW-1:0] CN   = CW'(-C);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = EW'(0);
  localparam logic signed [EW-1:0] MAXE = EW'((2 ** (DW - 1)) - 1);
  localparam logic signed [EW-1:0] MINE = EW'(-(2 ** (DW - 1)));
`ifdef PRACH_BF3_ROUND_EN
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (CW - 3));
`endif

  function automatic logic signed [EW-1:0] half(input logic signed [DW-1:0] x);
    logic signed [EW-1:0] e;
    e = EW'(x);
`ifdef PRACH_BF3_ROUND_EN
    return (e + ONE) >>> 1;
`else
    // bias negatives by one so the shift truncates toward zero
    return (e + (e[EW-1] ? ONE : ZERO)) >>> 1;
`endif
  endfunction

  // {overflow, clipped value}
  function automatic logic [DW:0] sat(input logic signed [EW-1:0] v);
    if (v > MAXE)      return {1'b1, MAXE[DW-1:0]};
    else if (v < MINE) return {1'b1, MINE[DW-1:0]};
    else               return {1'b0, v[DW-1:0]};
  endfunction

  function automatic logic [DW-1:0] cmul(input logic signed [CW-1:0] k,
                                         input logic signed [DW-1:0] x);
    logic signed [PW-1:0] p;
    p = PW'(k) * PW'(x);
`ifdef PRACH_BF3_ROUND_EN
    p = p + RND;
`endif
    return p[PW-3:CW-2];
  endfunction

  phase_e phase_q, phase_d, bp;
  logic signed [DW-1:0] x0r_q, x0r_d, x0i_q, x0i_d, x1r_q, x1r_d, x1i_q, x1i_d;
  logic [DW-1:0] pend_r_q, pend_r_d, pend_i_q, pend_i_d;
  logic [DW-1:0] res_r, res_i;
  logic          res_ov, serr;
  logic [DW:0]   y0r_s, y0i_s, y1r_s, y1i_s;
  logic [DW-1:0] y2r, y2i;
  logic [LW-1:0] dl_in, dl_out;

  assign y0r_s = sat(EW'(x0r_q) + EW'($signed(din_dr)));
  assign y0i_s = sat(EW'(x0i_q) + EW'($signed(din_di)));
  assign y1r_s = sat(EW'(x0r_q) - half(x1r_q));
  assign y1i_s = sat(EW'(x0i_q) - half(x1i_q));
  // inv=0: y2 = j*c*x2, inv=1: y2 = -j*c*x2; sign folded into the coefficient
  assign y2r   = cmul(inv ? CP : CN, $signed(din_di));
  assign y2i   = cmul(inv ? CN : CP, $signed(din_dr));

  always_comb begin
    bp       = sync_in ? PH_X0 : phase_q;
    serr     = din_dv & sync_in & (phase_q != PH_X0);
    phase_d  = phase_q;
    x0r_d    = x0r_q;
    x0i_d    = x0i_q;
    x1r_d    = x1r_q;
    x1i_d    = x1i_q;
    pend_r_d = pend_r_q;
    pend_i_d = pend_i_q;
    res_r    = pend_r_q;
    res_i    = pend_i_q;
    res_ov   = 1'b0;
    case (bp)
      PH_X0: begin
        if (din_dv) begin
          phase_d = PH_X1;
          x0r_d   = $signed(din_dr);
          x0i_d   = $signed(din_di);
        end
      end
      PH_X1: begin
        res_r  = y0r_s[DW-1:0];
        res_i  = y0i_s[DW-1:0];
        res_ov = y0r_s[DW] | y0i_s[DW];
        if (din_dv) begin
          phase_d = PH_X2;
          x1r_d   = $signed(din_dr);
          x1i_d   = $signed(din_di);
        end
      end
      default: begin
        res_r  = y1r_s[DW-1:0];
        res_i  = y1i_s[DW-1:0];
        res_ov = y1r_s[DW] | y1i_s[DW];
        if (din_dv) begin
          phase_d  = PH_X0;
          pend_r_d = y2r;
          pend_i_d = y2i;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_X0;
      x0r_q    <= '0;
      x0i_q    <= '0;
      x1r_q    <= '0;
      x1i_q    <= '0;
      pend_r_q <= '0;
      pend_i_q <= '0;
    end else begin
      phase_q  <= phase_d;
      x0r_q    <= x0r_d;
      x0i_q    <= x0i_d;
      x1r_q    <= x1r_d;
      x1i_q    <= x1i_d;
      pend_r_q <= pend_r_d;
      pend_i_q <= pend_i_d;
    end
  end

  // four delay stages plus the output register give the 5-cycle alignment
  assign dl_in = {din_dv, sync_in, serr, res_ov & din_dv, res_r, res_i};

  delay #(.W(LW), .DEPTH(4)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dl_in),
    .q     (dl_out)
  );

  logic          dv_q, dv_d, so_q, so_d, ovf_q, ovf_d, se_q, se_d;
  logic [DW-1:0] dr_q, dr_d, di_q, di_d;

  always_comb begin
    dv_d  = dl_out[LW-1];
    so_d  = dl_out[LW-2];
    se_d  = dl_out[LW-1] & dl_out[LW-3];
    ovf_d = dl_out[LW-1] & dl_out[LW-4];
    dr_d  = dr_q;
    di_d  = di_q;
    if (dl_out[LW-1]) begin
      dr_d = dl_out[2*DW-1:DW];
      di_d = dl_out[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q  <= 1'b0;
      so_q  <= 1'b0;
      se_q  <= 1'b0;
      ovf_q <= 1'b0;
      dr_q  <= '0;
      di_q  <= '0;
    end else begin
      dv_q  <= dv_d;
      so_q  <= so_d;
      se_q  <= se_d;
      ovf_q <= ovf_d;
      dr_q  <= dr_d;
      di_q  <= di_d;
    end
  end

  assign dout_dv  = dv_q;
  assign sync_out = so_q;
  assign sync_err = se_q;
  assign ovf      = ovf_q;
  assign dout_dr  = dr_q;
  assign dout_di  = di_q;

endmodule

// File: tb/tb_prach_ditfft3_bf2_p.sv
// Randomized bench for prach_ditfft3_bf2_p against a per-cycle expectation table.
module tb_prach_ditfft3_bf2_p;

  localparam int DW   = 18;
  localparam int CW   = 18;
  localparam int C    = 56756;
  localparam int LAT  = 5;
  localparam int NEX  = 8000;
  localparam int SMAX = 131071;
  localparam int SMIN = -131072;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din_dr, din_di, dout_dr, dout_di;
  logic          din_dv, sync_in, inv, dout_dv, sync_out, ovf, sync_err;

  always #5 clk = ~clk;

  prach_ditfft3_bf2_p #(.DW(DW), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dr   (din_dr),
    .din_di   (din_di),
    .din_dv   (din_dv),
    .sync_in  (sync_in),
    .inv      (inv),
    .dout_dr  (dout_dr),
    .dout_di  (dout_di),
    .dout_dv  (dout_dv),
    .sync_out (sync_out),
    .ovf      (ovf),
    .sync_err (sync_err)
  );

  typedef struct {
    bit dv, sy, se, ov;
    int re, im;
  } exp_t;

  exp_t ex [NEX];
  int tests = 0, fails = 0, n = 0;
  int ph = 0, x0r = 0, x0i = 0, x1r = 0, x1i = 0, pr = 0, pim = 0;
  int last_re = 0, last_im = 0;

  function automatic int fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return int'(q);
  endfunction

  // k * x scaled by 2^-(CW-2)
  function automatic int prod(input int k, input int x);
`ifdef PRACH_BF3_ROUND_EN
    return fdiv(longint'(k) * x + 32768, 65536);
`else
    return fdiv(longint'(k) * x, 65536);
`endif
  endfunction

  function automatic int half(input int x);
`ifdef PRACH_BF3_ROUND_EN
    return fdiv(x + 1, 2);
`else
    return x / 2;
`endif
  endfunction

  function automatic bit oor(input int v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  function automatic int clip(input int v);
    return v > SMAX ? SMAX : (v < SMIN ? SMIN : v);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, n, act, expv);
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    e = ex[n];
    if (e.dv) begin
      last_re = e.re;
      last_im = e.im;
    end
    chk("dout_dv", int'(dout_dv), int'(e.dv));
    chk("sync_out", int'(sync_out), int'(e.sy));
    chk("sync_err", int'(sync_err), int'(e.se));
    chk("ovf", int'(ovf), int'(e.ov));
    chk("dout_dr", int'($signed(dout_dr)), last_re);
    chk("dout_di", int'($signed(dout_di)), last_im);
  endtask

  task automatic step(input bit dv, input bit sy, input int re, input int im, input bit iv);
    exp_t e;
    @(negedge clk);
    check_cycle();
    din_dv  = dv;
    sync_in = sy;
    din_dr  = re[DW-1:0];
    din_di  = im[DW-1:0];
    inv     = iv;
    e = '{dv: dv, sy: sy, se: 1'b0, ov: 1'b0, re: 0, im: 0};
    if (dv) begin
      e.se = sy && (ph != 0);
      if (sy) ph = 0;
      case (ph)
        0: begin
          e.re = pr; e.im = pim;
          x0r = re; x0i = im;
        end
        1: begin
          e.re = clip(x0r + re); e.im = clip(x0i + im);
          e.ov = oor(x0r + re) || oor(x0i + im);
          x1r = re; x1i = im;
        end
        default: begin
          e.re = clip(x0r - half(x1r)); e.im = clip(x0i - half(x1i));
          e.ov = oor(x0r - half(x1r)) || oor(x0i - half(x1i));
          pr  = prod(iv ? C : -C, im);
          pim = prod(iv ? -C : C, re);
        end
      endcase
      ph = (ph + 1) % 3;
    end
    ex[n + LAT] = e;
    n++;
  endtask

  task automatic beat(input int re, input int im, input bit iv = 1'b0, input bit sy = 1'b0);
    step(1'b1, sy, re, im, iv);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      check_cycle();
      rst_n   = 1'b0;
      din_dv  = 1'b0;
      sync_in = 1'b0;
      for (int k = n; k <= n + LAT; k++) ex[k] = '{default: 0};
      ph = 0; x0r = 0; x0i = 0; x1r = 0; x1i = 0; pr = 0; pim = 0;
      last_re = 0; last_im = 0;
      n++;
    end
    @(negedge clk);
    check_cycle();
    rst_n = 1'b1;
    n++;
  endtask

  // model output for the most recently driven beat
  function automatic exp_t lastx();
    return ex[n - 1 + LAT];
  endfunction

  initial begin
    exp_t e;
    int r;
    rst_n = 1'b0; din_dv = 1'b0; sync_in = 1'b0; inv = 1'b0;
    din_dr = '0; din_di = '0;
    for (int k = 0; k < NEX; k++) ex[k] = '{default: 0};
    #12;
    chk("rst_dout_dr", int'(dout_dr), 0);
    chk("rst_dv_ovf_sync", int'({dout_dv, ovf, sync_err, sync_out}), 0);
    do_reset(2);

    beat(1000, 0);
    beat(200, 0);                 e = lastx(); chk("pin_y0_1200", e.re, 1200);
    beat(10000, 0, 1'b0);         e = lastx(); chk("pin_y1_900", e.re, 900);
    beat(0, 0);                   e = lastx(); chk("pin_y2a_im", e.im, 8660);
                                              chk("pin_y2a_re", e.re, 0);
    beat(3, 0);
    beat(0, 10000, 1'b0);         e = lastx();
`ifdef PRACH_BF3_ROUND_EN
    chk("pin_y1_half3", e.re, -2);
`else
    chk("pin_y1_half3", e.re, -1);
`endif
    beat(131071, 0);              e = lastx();
`ifdef PRACH_BF3_ROUND_EN
    chk("pin_y2b_re", e.re, -8660);
`else
    chk("pin_y2b_re", e.re, -8661);
`endif
    beat(1, 0);                   e = lastx(); chk("pin_sat_y0", e.re, 131071);
                                              chk("pin_sat_y0_ovf", int'(e.ov), 1);
    beat(10000, 0, 1'b1);
    beat(-131072, 0);             e = lastx();
`ifdef PRACH_BF3_ROUND_EN
    chk("pin_y2c_inv_im", e.im, -8660);
`else
    chk("pin_y2c_inv_im", e.im, -8661);
`endif
    beat(131071, 0);
    beat(0, 10000, 1'b1);         e = lastx(); chk("pin_sat_y1", e.re, -131072);
                                              chk("pin_sat_y1_ovf", int'(e.ov), 1);
    beat(5, 0);                   e = lastx(); chk("pin_y2d_inv_re", e.re, 8660);
    beat(7, 0, 1'b0, 1'b1);       e = lastx(); chk("pin_sync_err", int'(e.se), 1);
    beat(9, 0);                   e = lastx(); chk("pin_resync_y0", e.re, 16);
    beat(1, 0);
    for (int i = 0; i < 7; i++) idle();

    beat(100, 0);
    beat(40, 0);
    do_reset(2);
    beat(50, 60);                 e = lastx(); chk("pin_y2_after_rst", e.re | e.im, 0);
    beat(1, 2);
    beat(3, 4);

    while (n < NEX - 40) begin
      r = $urandom_range(0, 399);
      if (r == 0) do_reset($urandom_range(1, 3));
      else if (r < 130) idle();
      else step(1'b1, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 262143)) - 131072,
                int'($urandom_range(0, 262143)) - 131072, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 10; i++) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prach_ditfft3_bf2_p.md
PRACH_DITFFT3_BF2_P -- requirements
Module: prach_ditfft3_bf2_p

Interface
REQ-001 SHALL have parameter DW, 18, signed data width of every real/imag component.
REQ-002 SHALL have parameter CW, 18, signed coefficient width; the coefficient carries CW-2 fractional bits.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports din_dr, din_di  input  DW each  signed input sample, real/imag.
REQ-006 SHALL have port din_dv  input  1  input beat valid; gaps are allowed anywhere.
REQ-007 SHALL have port sync_in  input  1  when high with din_dv, marks x0 of a triple.
REQ-008 SHALL have port inv  input  1  twiddle direction, sampled on the x2 beat.
REQ-009 SHALL have ports dout_dr, dout_di  output  DW each  signed result, real/imag.
REQ-010 SHALL have ports dout_dv, sync_out  output  1 each  din_dv and sync_in delayed by exactly 5 cycles.
REQ-011 SHALL have port ovf  output  1  pulses with a beat whose result saturated.
REQ-012 SHALL have port sync_err  output  1  pulses with the beat of a misaligned sync.

Function
REQ-013 SHALL treat valid beats as triples (x0,x1,x2) using a phase counter 0->1->2->0 that advances only on din_dv; invalid cycles change no data state.
REQ-014 SHALL compute y0=x0+x1, y1=x0-x1/2 and y2=j*c*x2 (inv=0) or -j*c*x2 (inv=1), where c=round(cos(pi/6)*2^(CW-2)), which is 56756 for CW=18.
REQ-015 SHALL, for inv=0, form y2.re=-c*x2.im and y2.im=c*x2.re; for inv=1, it SHALL negate both.
REQ-016 SHALL take the product bits [DW+CW-3:CW-2] of the DW+CW-bit product (a multiply cannot overflow).
REQ-017 SHALL output each result 5 cycles after the beat it is aligned to, in this order:
  - x1 beat carries y0;
  - x2 beat carries y1;
  - the next x0 beat carries y2 of the previous triple.
REQ-018 SHALL hold the pending y2 across any gap until the next x0 beat; the first x0 after reset outputs 0.
REQ-019 SHALL saturate y0 and y1 to [-2^(DW-1), 2^(DW-1)-1] and assert ovf on that output beat.
REQ-020 SHALL force phase to 0 on a sync_in beat (that beat is x0); if phase was not 0, sync_err SHALL pulse on the aligned output beat and the partial triple SHALL be discarded.
REQ-021 SHALL hold dout_dr and dout_di at their last value when dout_dv=0.

Reset
REQ-022 SHALL, while rst_n=0, clear phase, the pending y2, the delay lines and all outputs (dout_*, dout_dv, sync_out, ovf, sync_err) to 0.
REQ-023 SHALL, when reset arrives mid-triple, discard the partial triple; the first beat after reset is phase 0.

Configuration
REQ-024 SHALL, with PRACH_BF3_ROUND_EN defined, round half-up:
  - add 2^(CW-3) to the product before taking its bits;
  - compute x1/2 as (x1+1)>>>1.
REQ-025 SHALL, without PRACH_BF3_ROUND_EN, truncate:
  - product floored;
  - x1/2 truncated toward zero.
  Latency SHALL be unchanged in both builds.

Structure
REQ-026 SHALL take the phase enum (PH_X0/PH_X1/PH_X2) and the cos(pi/6) coefficient function of CW from the shared package prach_pkg.
REQ-027 SHALL build the 5-cycle control and data alignment from the existing sub-module delay; no other sub-module.

Verification (DW=CW=18)
REQ-028 SHALL check: x0=1000, x1=200, gapless beats -> y0=1200, y1=900, 5 cycles after the x1 and x2 beats respectively.
REQ-029 SHALL check: x2=(10000,0), then x2=(0,10000), inv=0 ->
  - y2=(0,8660);
  - y2=(-8661,0) when truncating, (-8660,0) with PRACH_BF3_ROUND_EN;
  - inv=1 negates each result.
REQ-030 SHALL check: x0=0, x1=3 -> y1=-1 when truncating, -2 with rounding.
REQ-031 SHALL check saturation:
  - x0=131071, x1=1 -> y0=131071, ovf=1;
  - x0=-131072, x1=131071 -> y1=-131072, ovf=1.
REQ-032 SHALL check: sync_in on the x1 beat -> sync_err pulses 5 cycles later, phase restarts there, and no y1 is emitted for the discarded triple.
REQ-033 SHALL check: random gaps between beats, and rst_n pulsed mid-triple -> results match the gapless run; after reset all outputs are 0 and the first y2 is 0.
